// File: rtl/buffer_access_ctrl_if.sv
// buffer_access_ctrl_if: request/strobe bundle between USB/AHB requesters and the buffer access controller
interface buffer_access_ctrl_if;
  logic       rx_byte_valid;
  logic       rx_packet_done;
  logic       tx_byte_req;
  logic       ahb_read_req;
  logic       ahb_write_req;
  logic [1:0] ahb_size;
  logic       tx_start;
  logic       flush_req;
  logic       buf_store_rx;
  logic       buf_get_rx;
  logic       buf_store_tx;
  logic       buf_get_tx;
  logic       buf_clear;
  logic [1:0] buf_data_size;
  logic       buf_reserved;
  logic       ahb_ack;
  logic       ahb_err;
  logic       rx_overrun;
  logic       rx_data_ready;
  logic       tx_sending;
  logic [6:0] byte_count;
  modport master (
    output rx_byte_valid, rx_packet_done, tx_byte_req, ahb_read_req, ahb_write_req,
           ahb_size, tx_start, flush_req,
    input  buf_store_rx, buf_get_rx, buf_store_tx, buf_get_tx, buf_clear, buf_data_size,
           buf_reserved, ahb_ack, ahb_err, rx_overrun, rx_data_ready, tx_sending, byte_count
  );
  modport slave (
    input  rx_byte_valid, rx_packet_done, tx_byte_req, ahb_read_req, ahb_write_req,
           ahb_size, tx_start, flush_req,
    output buf_store_rx, buf_get_rx, buf_store_tx, buf_get_tx, buf_clear, buf_data_size,
           buf_reserved, ahb_ack, ahb_err, rx_overrun, rx_data_ready, tx_sending, byte_count
  );
endinterface

// File: rtl/buffer_access_ctrl.sv
// buffer_access_ctrl: arbitrates the shared endpoint buffer between USB RX/TX and AHB,
// issuing registered single-cycle buffer strobes and mirroring the fill level.
module buffer_access_ctrl #(
  parameter int BUF_DEPTH = 64
) (
  input logic                 clk,
  input logic                 rst,
  buffer_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RX_FILL, RX_READY, TX_FILL, TX_SEND} state_t;
  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       store_rx_q, store_rx_d;
  logic       get_rx_q, get_rx_d;
  logic       store_tx_q, store_tx_d;
  logic       get_tx_q, get_tx_d;
  logic       clear_q, clear_d;
  logic [1:0] size_q, size_d;
  logic       reserved_q, reserved_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       overrun_q, overrun_d;
  logic       ready_q, ready_d;
  logic       sending_q, sending_d;
  logic [7:0] n8;
  logic [6:0] n7;
  logic       fits_wr, fits_rd, full;
  // Grant checks are done at 8 bits so count+n cannot wrap.
  assign n8      = 8'(bus.ahb_size) + 8'd1;
  assign n7      = n8[6:0];
  assign fits_wr = ({1'b0, count_q} + n8) <= 8'(BUF_DEPTH);
  assign fits_rd = n8 <= {1'b0, count_q};
  assign full    = count_q == 7'(BUF_DEPTH);
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    store_rx_d = 1'b0;
    get_rx_d   = 1'b0;
    store_tx_d = 1'b0;
    get_tx_d   = 1'b0;
    clear_d    = 1'b0;
    size_d     = 2'd0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    overrun_d  = 1'b0;
    if (bus.flush_req) begin
      clear_d = 1'b1;
      count_d = 7'd0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          err_d = bus.ahb_read_req | (bus.rx_byte_valid & bus.ahb_write_req);
          if (bus.rx_byte_valid) begin
            store_rx_d = 1'b1;
            count_d    = count_q + 7'd1;
            state_d    = RX_FILL;
          end else if (bus.ahb_write_req) begin
            store_tx_d = 1'b1;
            size_d     = bus.ahb_size;
            ack_d      = 1'b1;
            count_d    = count_q + n7;
            state_d    = TX_FILL;
          end
        end
        RX_FILL: begin
          err_d      = bus.ahb_read_req | bus.ahb_write_req;
          overrun_d  = bus.rx_byte_valid & full;
          store_rx_d = bus.rx_byte_valid & !full;
          count_d    = store_rx_d ? count_q + 7'd1 : count_q;
          if (bus.rx_packet_done) state_d = (count_d == 7'd0) ? IDLE : RX_READY;
        end
        RX_READY: begin
          overrun_d = bus.rx_byte_valid;
          get_rx_d  = bus.ahb_read_req & fits_rd;
          ack_d     = get_rx_d;
          size_d    = get_rx_d ? bus.ahb_size : 2'd0;
          err_d     = bus.ahb_write_req | (bus.ahb_read_req & !fits_rd);
          count_d   = get_rx_d ? count_q - n7 : count_q;
          state_d   = (count_d == 7'd0) ? IDLE : RX_READY;
        end
        TX_FILL: begin
          overrun_d  = bus.rx_byte_valid;
          store_tx_d = bus.ahb_write_req & fits_wr;
          ack_d      = store_tx_d;
          size_d     = store_tx_d ? bus.ahb_size : 2'd0;
          err_d      = bus.ahb_read_req | (bus.ahb_write_req & !fits_wr);
          count_d    = store_tx_d ? count_q + n7 : count_q;
          if (bus.tx_start) state_d = (count_d == 7'd0) ? IDLE : TX_SEND;
        end
        TX_SEND: begin
          overrun_d = bus.rx_byte_valid;
          err_d     = bus.ahb_read_req | bus.ahb_write_req;
          get_tx_d  = bus.tx_byte_req & (count_q != 7'd0);
          count_d   = get_tx_d ? count_q - 7'd1 : count_q;
          state_d   = (count_d == 7'd0) ? IDLE : TX_SEND;
        end
        default: state_d = IDLE;
      endcase
    end
    reserved_d = (state_d == TX_FILL) || (state_d == TX_SEND);
    ready_d    = state_d == RX_READY;
    sending_d  = state_d == TX_SEND;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 7'd0;
      store_rx_q <= 1'b0;
      get_rx_q   <= 1'b0;
      store_tx_q <= 1'b0;
      get_tx_q   <= 1'b0;
      clear_q    <= 1'b0;
      size_q     <= 2'd0;
      reserved_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b0;
      sending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      store_rx_q <= store_rx_d;
      get_rx_q   <= get_rx_d;
      store_tx_q <= store_tx_d;
      get_tx_q   <= get_tx_d;
      clear_q    <= clear_d;
      size_q     <= size_d;
      reserved_q <= reserved_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
      ready_q    <= ready_d;
      sending_q  <= sending_d;
    end
  end
  assign bus.buf_store_rx  = store_rx_q;
  assign bus.buf_get_rx    = get_rx_q;
  assign bus.buf_store_tx  = store_tx_q;
  assign bus.buf_get_tx    = get_tx_q;
  assign bus.buf_clear     = clear_q;
  assign bus.buf_data_size = size_q;
  assign bus.buf_reserved  = reserved_q;
  assign bus.ahb_ack       = ack_q;
  assign bus.ahb_err       = err_q;
  assign bus.rx_overrun    = overrun_q;
  assign bus.rx_data_ready = ready_q;
  assign bus.tx_sending    = sending_q;
  assign bus.byte_count    = count_q;
endmodule

// File: tb/tb_buffer_access_ctrl.sv
// tb_buffer_access_ctrl: directed steps; each step queues its expected output word, which is popped and checked after the edge.
module tb_buffer_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  buffer_access_ctrl_if bus();
  buffer_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic       store_rx, get_rx, store_tx, get_tx, clear;
    logic [1:0] size;
    logic       reserved, ack, err, overrun, ready, sending;
    logic [6:0] count;
  } out_t;
  localparam int I_RV = 1, I_DONE = 2, I_TXR = 4, I_RD = 8, I_WR = 16, I_ST = 32, I_FL = 64, I_RS = 128;
  localparam int O_SR = 1, O_GR = 2, O_ST = 4, O_GT = 8, O_CL = 16, O_RES = 32, O_AK = 64,
                 O_ER = 128, O_OV = 256, O_RDY = 512, O_SD = 1024;
  out_t exp_q[$];
  function automatic out_t mo(int f, logic [1:0] sz, int cnt);
    out_t o;
    o.store_rx = (f & O_SR) != 0;
    o.get_rx   = (f & O_GR) != 0;
    o.store_tx = (f & O_ST) != 0;
    o.get_tx   = (f & O_GT) != 0;
    o.clear    = (f & O_CL) != 0;
    o.size     = sz;
    o.reserved = (f & O_RES) != 0;
    o.ack      = (f & O_AK) != 0;
    o.err      = (f & O_ER) != 0;
    o.overrun  = (f & O_OV) != 0;
    o.ready    = (f & O_RDY) != 0;
    o.sending  = (f & O_SD) != 0;
    o.count    = 7'(cnt);
    return o;
  endfunction
  function automatic out_t sample();
    out_t o;
    o = {bus.buf_store_rx, bus.buf_get_rx, bus.buf_store_tx, bus.buf_get_tx, bus.buf_clear,
         bus.buf_data_size, bus.buf_reserved, bus.ahb_ack, bus.ahb_err, bus.rx_overrun,
         bus.rx_data_ready, bus.tx_sending, bus.byte_count};
    return o;
  endfunction
  task automatic step(input string tag, input int f, input logic [1:0] sz, input out_t e);
    out_t got, want;
    rst                = (f & I_RS) != 0;
    bus.rx_byte_valid  = (f & I_RV) != 0;
    bus.rx_packet_done = (f & I_DONE) != 0;
    bus.tx_byte_req    = (f & I_TXR) != 0;
    bus.ahb_read_req   = (f & I_RD) != 0;
    bus.ahb_write_req  = (f & I_WR) != 0;
    bus.tx_start       = (f & I_ST) != 0;
    bus.flush_req      = (f & I_FL) != 0;
    bus.ahb_size       = sz;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = sample();
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask
  initial begin
    step("reset", I_RS, 2'd0, mo(0, 2'd0, 0));
    step("reset_hold", I_RS, 2'd0, mo(0, 2'd0, 0));
    step("idle", 0, 2'd0, mo(0, 2'd0, 0));
    for (int k = 1; k <= 4; k++) step("rx4_store", I_RV, 2'd0, mo(O_SR, 2'd0, k));
    step("rx4_done", I_DONE, 2'd0, mo(O_RDY, 2'd0, 4));
    step("rd_sz1_a", I_RD, 2'd1, mo(O_GR | O_AK | O_RDY, 2'd1, 2));
    step("rd_sz1_b", I_RD, 2'd1, mo(O_GR | O_AK, 2'd1, 0));
    step("idle_after_rd", 0, 2'd0, mo(0, 2'd0, 0));
    for (int k = 1; k <= 64; k++) step("rx64_store", I_RV, 2'd0, mo(O_SR, 2'd0, k));
    step("rx_overrun", I_RV, 2'd0, mo(O_OV, 2'd0, 64));
    step("rx64_done", I_DONE, 2'd0, mo(O_RDY, 2'd0, 64));
    for (int k = 1; k <= 16; k++)
      step("rd_sz3", I_RD, 2'd3, mo(O_GR | O_AK | (k < 16 ? O_RDY : 0), 2'd3, 64 - 4 * k));
    step("rd_in_idle_err", I_RD, 2'd0, mo(O_ER, 2'd0, 0));
    for (int k = 1; k <= 16; k++) step("wr_sz3", I_WR, 2'd3, mo(O_ST | O_AK | O_RES, 2'd3, 4 * k));
    step("wr_full_err", I_WR, 2'd3, mo(O_ER | O_RES, 2'd0, 64));
    step("tx_start", I_ST, 2'd0, mo(O_RES | O_SD, 2'd0, 64));
    for (int k = 1; k <= 64; k++)
      step("tx_get", I_TXR, 2'd0, mo(O_GT | (k < 64 ? O_RES | O_SD : 0), 2'd0, 64 - k));
    step("idle_after_tx", 0, 2'd0, mo(0, 2'd0, 0));
    step("rx2_a", I_RV, 2'd0, mo(O_SR, 2'd0, 1));
    step("rx2_b", I_RV, 2'd0, mo(O_SR, 2'd0, 2));
    step("rx2_done", I_DONE, 2'd0, mo(O_RDY, 2'd0, 2));
    step("rd_too_big", I_RD, 2'd3, mo(O_ER | O_RDY, 2'd0, 2));
    step("ready_wr_err", I_WR, 2'd0, mo(O_ER | O_RDY, 2'd0, 2));
    step("flush_ready", I_FL, 2'd0, mo(O_CL, 2'd0, 0));
    step("rx_wr_same", I_RV | I_WR, 2'd1, mo(O_SR | O_ER, 2'd0, 1));
    step("rxfill_rd_err", I_RD, 2'd0, mo(O_ER, 2'd0, 1));
    step("flush_rxfill", I_FL, 2'd0, mo(O_CL, 2'd0, 0));
    for (int k = 1; k <= 15; k++) step("wr60", I_WR, 2'd3, mo(O_ST | O_AK | O_RES, 2'd3, 4 * k));
    step("wr62", I_WR, 2'd1, mo(O_ST | O_AK | O_RES, 2'd1, 62));
    step("wr_over_err", I_WR, 2'd3, mo(O_ER | O_RES, 2'd0, 62));
    step("wr64_exact", I_WR, 2'd1, mo(O_ST | O_AK | O_RES, 2'd1, 64));
    step("flush_txfill", I_FL, 2'd0, mo(O_CL, 2'd0, 0));
    for (int k = 1; k <= 5; k++) step("wr10", I_WR, 2'd1, mo(O_ST | O_AK | O_RES, 2'd1, 2 * k));
    step("tx_start10", I_ST, 2'd0, mo(O_RES | O_SD, 2'd0, 10));
    step("send_rx_overrun", I_RV, 2'd0, mo(O_OV | O_RES | O_SD, 2'd0, 10));
    step("flush_send", I_FL | I_TXR, 2'd0, mo(O_CL, 2'd0, 0));
    step("idle_after_flush", 0, 2'd0, mo(0, 2'd0, 0));
    step("wr_pre_rst_a", I_WR, 2'd3, mo(O_ST | O_AK | O_RES, 2'd3, 4));
    step("wr_pre_rst_b", I_WR, 2'd3, mo(O_ST | O_AK | O_RES, 2'd3, 8));
    step("rst_mid_txfill", I_RS | I_WR, 2'd3, mo(0, 2'd0, 0));
    step("idle_after_rst", 0, 2'd0, mo(0, 2'd0, 0));
    step("rx_after_rst", I_RV, 2'd0, mo(O_SR, 2'd0, 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/buffer_access_ctrl.md
# buffer_access_ctrl

Sequencing and arbitration controller for the shared 64-byte endpoint data buffer. It takes byte-level requests from the USB RX and USB TX engines and word-level requests from the AHB-Lite slave, and decides which side owns the buffer. It converts granted requests into single-cycle buffer strobes (store/get/clear, data size, reserved) and mirrors the buffer fill level internally, so grant decisions never wait on the buffer's occupancy output.

## Interface
Parameters:
- BUF_DEPTH, 64: buffer capacity in bytes; the count is 7 bits.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- rx_byte_valid  in  1  USB RX has a byte for the buffer (1-cycle pulse).
- rx_packet_done  in  1  USB RX finished the data packet (1-cycle pulse).
- tx_byte_req  in  1  USB TX wants the next byte (1-cycle pulse).
- ahb_read_req  in  1  AHB slave read of the RX data (1-cycle pulse).
- ahb_write_req  in  1  AHB slave write of TX data (1-cycle pulse).
- ahb_size  in  2  AHB transfer size; number of bytes n = ahb_size + 1.
- tx_start  in  1  software commit of the TX packet (1-cycle pulse).
- flush_req  in  1  software buffer flush (1-cycle pulse).
- buf_store_rx  out  1  strobe to the buffer store_rx_packet_data input.
- buf_get_rx  out  1  strobe to the buffer get_rx_data input.
- buf_store_tx  out  1  strobe to the buffer store_tx_data input.
- buf_get_tx  out  1  strobe to the buffer get_tx_packet_data input.
- buf_clear  out  1  strobe to the buffer clear input.
- buf_data_size  out  2  data_size to the buffer; valid while buf_get_rx or buf_store_tx is high.
- buf_reserved  out  1  buffer owned by the TX path.
- ahb_ack  out  1  AHB request granted.
- ahb_err  out  1  AHB request refused.
- rx_overrun  out  1  USB RX byte dropped.
- rx_data_ready  out  1  high in RX_READY.
- tx_sending  out  1  high in TX_SEND.
- byte_count  out  7  mirrored buffer occupancy, 0..64.

## Operation
- States: IDLE, RX_FILL, RX_READY, TX_FILL, TX_SEND.
- flush_req has the highest priority in every state:
  - buf_clear pulses and no other strobe fires that cycle.
  - byte_count goes to 0 and the state goes to IDLE.
  - Pending requests that cycle are dropped silently, with no ack or err.
- IDLE:
  - rx_byte_valid: store, count+1, go to RX_FILL.
  - Otherwise ahb_write_req: store n bytes, count+n, go to TX_FILL.
  - If both arrive in the same cycle, RX wins and the AHB write gets ahb_err.
  - ahb_read_req: ahb_err.
- RX_FILL:
  - rx_byte_valid with count<64: store, count+1.
  - rx_byte_valid with count==64: rx_overrun pulse, byte dropped.
  - rx_packet_done: go to RX_READY, or to IDLE if count==0.
  - Any AHB request: ahb_err.
- RX_READY:
  - ahb_read_req with n<=count: buf_get_rx pulse, buf_data_size=ahb_size, count-n, ahb_ack.
  - ahb_read_req with n>count: ahb_err, no strobe.
  - When count reaches 0, go to IDLE.
  - rx_byte_valid: rx_overrun.
  - ahb_write_req: ahb_err.
- TX_FILL (buf_reserved=1):
  - ahb_write_req with count+n<=64: store, count+n, ahb_ack.
  - ahb_write_req with count+n>64: ahb_err.
  - tx_start: go to TX_SEND, or to IDLE if count==0.
  - ahb_read_req: ahb_err.
  - rx_byte_valid: rx_overrun.
- TX_SEND (buf_reserved=1):
  - tx_byte_req with count>0: buf_get_tx pulse, count-1.
  - When count goes from 1 to 0, go to IDLE and drop buf_reserved the same cycle.
  - All AHB requests: ahb_err.
  - rx_byte_valid: rx_overrun.
- Count arithmetic is done at 7 bits. The grant check uses count+n <= 64, computed at 8 bits so it cannot overflow.

## Timing
- All outputs are registered.
- Reset value of every output is 0. After reset: state IDLE, byte_count 0.
- A request sampled on rising edge k produces its strobe, ack/err or overrun in cycle k+1, high for exactly one cycle.
- byte_count and the state update at edge k+1, together with the strobe.
- Back-to-back requests on consecutive cycles are each granted, one per cycle; no bubble is required.
- rx_data_ready and tx_sending follow the registered state.
- rst asserted mid-transfer:
  - On the next edge, everything returns to reset values.
  - No buf_clear is issued; the buffer has its own reset.

## Test plan
- Reset, then 4 rx_byte_valid pulses, then rx_packet_done -> 4 buf_store_rx pulses, byte_count=4, rx_data_ready=1. Then ahb_read_req with size 1 twice -> buf_get_rx with buf_data_size=1 each time, ahb_ack, byte_count 2 then 0, back to IDLE.
- Fill with 64 RX bytes, then send a 65th -> rx_overrun pulse, no strobe, byte_count holds 64. Then 16 reads of size 3 -> ahb_ack 16 times, count 0, IDLE.
- ahb_write_req with size 3, sent 16 times -> byte_count=64, buf_reserved=1. A 17th write -> ahb_err. tx_start, then 64 tx_byte_req -> 64 buf_get_tx pulses; buf_reserved falls with the last one.
- In RX_READY with count=2, ahb_read_req with size 3 -> ahb_err, no buf_get_rx, count stays 2.
- Same-cycle rx_byte_valid and ahb_write_req in IDLE -> buf_store_rx, ahb_err, state RX_FILL.
- flush_req in TX_SEND with count=10 and a simultaneous tx_byte_req -> only buf_clear fires, byte_count=0, IDLE. A separate test asserts rst mid-TX_FILL -> all outputs 0 on the next edge.
